// File: rtl/npc_lsu_pkg.sv
// rtl/npc_lsu_pkg.sv - shared state type, funct3 codes and access-size helper for the load/store unit
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  // Access size in bytes: 1, 2, 4 or 8, taken from the low two funct3 bits.
  function automatic logic [3:0] lsu_size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane placement of store data, load extraction/extension and access checks
module lsu_align
  import npc_lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [2:0]  i_offset,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [63:0] i_wdata,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_mask,
  output logic [63:0] o_load_data,
  output logic        o_misaligned,
  output logic        o_illegal
);

  logic [3:0]  w_size;
  logic [2:0]  w_low_mask;
  logic [7:0]  w_lane_mask;
  logic [63:0] w_shifted;

  assign w_size     = lsu_size_bytes(i_funct3);
  // Offset bits that must be zero for a naturally aligned access (size 8 -> 3'b111).
  assign w_low_mask = 3'(w_size - 4'd1);

  assign o_misaligned = (i_load | i_store) & (|(i_offset & w_low_mask));
  assign o_illegal    = (i_load & i_store)
                      | (i_load & (i_funct3 > F3_LWU))
                      | (i_store & (i_funct3 > F3_SD));

  assign o_mem_wdata = i_wdata << {i_offset, 3'b000};
  assign o_mem_mask  = w_lane_mask << i_offset;
  assign w_shifted   = i_rdata >> {i_offset, 3'b000};

  // Unshifted write mask for the store size.
  always_comb begin
    w_lane_mask = 8'h00;
    case (i_funct3)
      F3_SB:   w_lane_mask = 8'h01;
      F3_SH:   w_lane_mask = 8'h03;
      F3_SW:   w_lane_mask = 8'h0F;
      F3_SD:   w_lane_mask = 8'hFF;
      default: w_lane_mask = 8'h00;
    endcase
  end

  // Keep the low size bytes of the lane-shifted word and sign/zero extend.
  always_comb begin
    o_load_data = 64'd0;
    case (i_funct3)
      F3_LB:   o_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
      F3_LH:   o_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
      F3_LW:   o_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
      F3_LD:   o_load_data = w_shifted;
      F3_LBU:  o_load_data = {56'd0, w_shifted[7:0]};
      F3_LHU:  o_load_data = {48'd0, w_shifted[15:0]};
      F3_LWU:  o_load_data = {32'd0, w_shifted[31:0]};
      default: o_load_data = 64'd0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - one-at-a-time load/store controller between execute, MEM and writeback
module lsu_ctrl
  import npc_lsu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [2:0]  in_funct3,
  input  logic [63:0] in_addr,
  input  logic [63:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_err,
  output logic        mem_ren,
  output logic [63:0] mem_raddr,
  input  logic [63:0] mem_rdata,
  output logic        mem_wen,
  output logic [63:0] mem_waddr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_mask
);

  localparam logic [15:0] LP_CNT_INIT = 16'(MEM_LAT - 1);

  lsu_state_t  r_state;
  lsu_state_t  w_state_nxt;
  logic        r_load;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [15:0] r_cnt;
  logic [63:0] r_out_rdata;
  logic [4:0]  r_out_rd;
  logic        r_out_err;

  logic        w_idle;
  logic        w_accept;
  logic        w_cnt_zero;
  logic [2:0]  w_al_funct3;
  logic [2:0]  w_al_offset;
  logic        w_al_load;
  logic        w_al_store;
  logic [63:0] w_load_data;
  logic        w_misaligned;
  logic        w_illegal;
  logic        w_err;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_cnt_zero = (r_cnt == 16'd0);

  // In IDLE the checker looks at the incoming request so the accept decision
  // is made this cycle; afterwards it works on the latched copy.
  assign w_al_funct3 = w_idle ? in_funct3   : r_funct3;
  assign w_al_offset = w_idle ? in_addr[2:0] : r_addr[2:0];
  assign w_al_load   = w_idle ? in_load     : r_load;
  assign w_al_store  = w_idle ? in_store    : r_store;
  assign w_err       = w_misaligned | w_illegal;

  lsu_align u_align (
    .i_funct3     (w_al_funct3),
    .i_offset     (w_al_offset),
    .i_load       (w_al_load),
    .i_store      (w_al_store),
    .i_wdata      (r_wdata),
    .i_rdata      (mem_rdata),
    .o_mem_wdata  (mem_wdata),
    .o_mem_mask   (mem_mask),
    .o_load_data  (w_load_data),
    .o_misaligned (w_misaligned),
    .o_illegal    (w_illegal)
  );

  assign mem_raddr = {r_addr[63:3], 3'b000};
  assign mem_waddr = {r_addr[63:3], 3'b000};
  assign out_rdata = r_out_rdata;
  assign out_rd    = r_out_rd;
  assign out_err   = r_out_err;

  // State register; reset drops straight to IDLE so strobes fall immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake/strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          if (w_err || (!in_load && !in_store)) begin
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        mem_ren = r_load;
        mem_wen = r_store & w_cnt_zero;
        if (w_cnt_zero) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request latch, wait counter and registered response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load      <= 1'b0;
      r_store     <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 64'd0;
      r_wdata     <= 64'd0;
      r_cnt       <= 16'd0;
      r_out_rdata <= 64'd0;
      r_out_rd    <= 5'd0;
      r_out_err   <= 1'b0;
    end else if (w_accept) begin
      r_load      <= in_load;
      r_store     <= in_store;
      r_funct3    <= in_funct3;
      r_addr      <= in_addr;
      r_wdata     <= in_wdata;
      r_cnt       <= LP_CNT_INIT;
      r_out_rdata <= 64'd0;
      r_out_rd    <= in_rd;
      r_out_err   <= w_err;
    end else if (r_state == ST_WAIT) begin
      if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 16'd1;
      end else if (r_load) begin
        r_out_rdata <= w_load_data;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl against a byte-array reference model
`timescale 1ns/1ps
module tb_lsu_ctrl;

  localparam int          LAT  = 3;
  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_load = 1'b0;
  logic        in_store = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [63:0] in_addr = 64'd0;
  logic [63:0] in_wdata = 64'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_err;
  logic        mem_ren;
  logic [63:0] mem_raddr;
  logic [63:0] mem_rdata;
  logic        mem_wen;
  logic [63:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_mask;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_rd(out_rd),
    .out_err(out_err),
    .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_mask(mem_mask)
  );

  logic [7:0] mem_b [0:127];
  logic [7:0] ref_b [0:127];

  always_comb begin
    mem_rdata = 64'd0;
    for (int i = 0; i < 8; i++) mem_rdata[8*i +: 8] = mem_b[{mem_raddr[6:3], 3'(i)}];
  end

  always @(posedge clk) begin
    if (mem_wen)
      for (int i = 0; i < 8; i++)
        if (mem_mask[i]) mem_b[{mem_waddr[6:3], 3'(i)}] <= mem_wdata[8*i +: 8];
  end

  typedef struct packed { logic [63:0] rdata; logic [4:0] rd; logic err; } resp_t;
  typedef struct packed { logic [63:0] addr; logic [63:0] data; logic [7:0] mask; } wr_t;

  resp_t exp_resp[$];
  wr_t   exp_wr[$];
  int    errors = 0;
  int    checks = 0;
  int    rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Response monitor: pop on each accepted output beat.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_resp.size() == 0) flag("resp_unexpected");
      else begin
        e = exp_resp.pop_front();
        check("resp_rdata", out_rdata, e.rdata);
        check("resp_rd", 64'(out_rd), 64'(e.rd));
        check("resp_err", 64'(out_err), 64'(e.err));
      end
    end
  end

  // Write monitor: every write pulse must match the next expected store.
  always @(negedge clk) begin
    wr_t e;
    logic [63:0] lanes;
    if (mem_wen) begin
      if (exp_wr.size() == 0) flag("wr_unexpected");
      else begin
        e = exp_wr.pop_front();
        for (int i = 0; i < 8; i++) lanes[8*i +: 8] = {8{e.mask[i]}};
        check("wr_addr", mem_waddr, e.addr);
        check("wr_mask", 64'(mem_mask), 64'(e.mask));
        check("wr_data", mem_wdata & lanes, e.data & lanes);
      end
    end
  end

  // Held response must not change while writeback stalls.
  logic        hold_v = 1'b0;
  logic [63:0] hold_rdata;
  logic [4:0]  hold_rd;
  logic        hold_err;
  always @(negedge clk) begin
    if (rst_n && hold_v) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_rdata", out_rdata, hold_rdata);
      check("hold_rd", 64'(out_rd), 64'(hold_rd));
      check("hold_err", 64'(out_err), 64'(hold_err));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    hold_v     <= rst_n && out_valid && !out_ready;
    hold_rdata <= out_rdata;
    hold_rd    <= out_rd;
    hold_err   <= out_err;
  end

  function automatic int sz(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  task automatic wait_ready(output bit ok);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 200);
    ok = in_ready;
    if (!ok) flag("in_ready_timeout");
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [6:0] off, input logic [63:0] wd, input logic [4:0] rd);
    in_valid = 1'b1; in_load = ld; in_store = st; in_funct3 = f3;
    in_addr = BASE + 64'(off); in_wdata = wd; in_rd = rd;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_load = 1'($urandom); in_store = 1'($urandom);
    in_funct3 = 3'($urandom); in_addr = {$urandom, $urandom};
    in_wdata = {$urandom, $urandom}; in_rd = 5'($urandom);
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [6:0] off, input logic [63:0] wd, input logic [4:0] rd);
    int s, lat_exp, ren_exp, wen_exp, n_ren, n_wen, k, o;
    bit err, ok, mem_op;
    logic [63:0] v;
    wr_t w;
    s      = sz(f3);
    mem_op = ld || st;
    err    = (ld && st) || (ld && f3 == 3'b111) || (st && f3[2]) || (mem_op && (int'(off) % s != 0));
    wait_ready(ok);
    if (!ok) return;
    drive(ld, st, f3, off, wd, rd);
    v = 64'd0; lat_exp = 1; ren_exp = 0; wen_exp = 0;
    if (mem_op && !err) begin
      lat_exp = LAT + 1;
      if (ld) begin
        ren_exp = LAT;
        for (int i = 0; i < s; i++) v[8*i +: 8] = ref_b[int'(off) + i];
        if (!f3[2] && s < 8 && v[8*s-1]) v = v | (~64'd0 << (8*s));
      end else begin
        wen_exp = 1;
        o = int'(off[2:0]);
        w.addr = (BASE + 64'(off)) & ~64'h7;
        w.data = 64'd0;
        w.mask = 8'd0;
        for (int i = 0; i < s; i++) begin
          w.mask[o+i]         = 1'b1;
          w.data[8*(o+i) +: 8] = wd[8*i +: 8];
          ref_b[int'(off) + i] = wd[8*i +: 8];
        end
        exp_wr.push_back(w);
      end
    end
    exp_resp.push_back('{rdata: v, rd: rd, err: err});
    n_ren = 0; n_wen = 0; k = 0;
    do begin
      @(negedge clk);
      k++;
      if (mem_ren) begin
        n_ren++;
        check("raddr", mem_raddr, (BASE + 64'(off)) & ~64'h7);
      end
      if (mem_wen) n_wen++;
    end while (!out_valid && k < 50);
    check("latency", 64'(k), 64'(lat_exp));
    check("ren_cycles", 64'(n_ren), 64'(ren_exp));
    check("wen_pulses", 64'(n_wen), 64'(wen_exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_err"}, 64'(out_err), 64'd0);
    check({tag, "_out_rdata"}, out_rdata, 64'd0);
    check({tag, "_out_rd"}, 64'(out_rd), 64'd0);
    check({tag, "_mem_ren"}, 64'(mem_ren), 64'd0);
    check({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
  endtask

  task automatic reset_mid_store();
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    drive(1'b0, 1'b1, 3'b011, 7'h20, 64'hDEAD_BEEF_CAFE_F00D, 5'd9);
    @(negedge clk);
    @(negedge clk);
    check("rst_wait2_wen", 64'(mem_wen), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int op, nbad;
    logic [2:0] f3;
    logic [6:0] off;
    for (int i = 0; i < 128; i++) begin
      mem_b[i] = 8'($urandom);
      ref_b[i] = mem_b[i];
    end
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    issue(1'b0, 1'b1, 3'b011, 7'h10, 64'h1122334455667788, 5'd1);
    issue(1'b0, 1'b1, 3'b000, 7'h13, 64'h00000000000000AB, 5'd2);
    issue(1'b0, 1'b1, 3'b010, 7'h10, 64'h0000000080000000, 5'd3);
    issue(1'b1, 1'b0, 3'b000, 7'h13, 64'd0, 5'd4);
    issue(1'b1, 1'b0, 3'b100, 7'h13, 64'd0, 5'd5);
    issue(1'b1, 1'b0, 3'b010, 7'h06, 64'd0, 5'd6);
    issue(1'b1, 1'b0, 3'b111, 7'h10, 64'd0, 5'd7);

    rdy_mode = 2;
    issue(1'b1, 1'b0, 3'b011, 7'h10, 64'd0, 5'd8);
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    @(negedge clk);
    check("bp_handshake_valid", 64'(out_valid & out_ready), 64'd1);
    check("bp_handshake_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("bp_idle_in_ready", 64'(in_ready), 64'd1);
    check("bp_idle_out_valid", 64'(out_valid), 64'd0);

    issue(1'b0, 1'b0, 3'b011, 7'h10, 64'h55, 5'd10);
    issue(1'b1, 1'b1, 3'b011, 7'h10, 64'h55, 5'd11);
    issue(1'b0, 1'b1, 3'b100, 7'h10, 64'h55, 5'd12);

    reset_mid_store();
    issue(1'b0, 1'b1, 3'b011, 7'h28, 64'h0123456789ABCDEF, 5'd13);
    issue(1'b1, 1'b0, 3'b011, 7'h28, 64'd0, 5'd14);
    issue(1'b1, 1'b0, 3'b011, 7'h20, 64'd0, 5'd15);

    rdy_mode = 1;
    for (int n = 0; n < 300; n++) begin
      op  = $urandom_range(0, 19);
      f3  = 3'($urandom);
      off = 7'($urandom);
      if ($urandom_range(0, 3) != 0) off = off & 7'(~(sz(f3) - 1));
      issue(op < 9 || op == 18, (op >= 9 && op < 18) || op == 18, f3, off,
            {$urandom, $urandom}, 5'($urandom));
    end
    rdy_mode = 0;
    repeat (5) @(negedge clk);

    check("resp_queue_drained", 64'(exp_resp.size()), 64'd0);
    check("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    nbad = 0;
    for (int i = 0; i < 128; i++) if (mem_b[i] !== ref_b[i]) nbad++;
    check("mem_image_bad_bytes", 64'(nbad), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting directly upstream of the DPI-backed `MEM` block. It accepts one memory request at a time from the execute stage over a valid/ready handshake. It drives the 8-byte-aligned read and write strobes into `MEM` and sign- or zero-extends load data. Each result (or an alignment/illegal-op error) is returned to writeback over a second valid/ready handshake.

## Interface
- `MEM_LAT`, default 1: number of WAIT cycles per memory access; legal range ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `in_load` in 1: request is a load.
- `in_store` in 1: request is a store.
- `in_funct3` in 3: RV64 size/sign code.
- `in_addr` in 64: byte address.
- `in_wdata` in 64: store data, LSB-aligned.
- `in_rd` in 5: destination register tag, carried to output.
- `out_valid` out 1: response valid.
- `out_ready` in 1: writeback accepts.
- `out_rdata` out 64: extended load data; 0 for stores and errors.
- `out_rd` out 5: tag of the request.
- `out_err` out 1: misaligned access or illegal funct3.
- `mem_ren` out 1: read enable to `MEM`.
- `mem_raddr` out 64: read address, `addr & ~7`.
- `mem_rdata` in 64: read data from `MEM`, combinational.
- `mem_wen` out 1: write enable to `MEM`.
- `mem_waddr` out 64: write address, `addr & ~7`.
- `mem_wdata` out 64: store data shifted to its byte lane.
- `mem_mask` out 8: byte-lane write mask.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, latch the request.
  - Error (illegal funct3 or misaligned) → RESP with `out_err`=1 and no memory access.
  - Neither load nor store → RESP with `out_rdata`=0, no error.
  - Otherwise → WAIT with counter=`MEM_LAT`-1.
  - `in_load` and `in_store` both high is illegal and reports an error.
- **WAIT**
  - `mem_ren` = load, for every WAIT cycle.
  - `mem_wen` = store, only while counter==0, so exactly one write pulse per store.
  - The counter decrements each cycle.
  - At counter==0, capture the extended load data and go → RESP.
- **RESP**
  - `out_valid`=1; all `out_*` are registered and held stable until `out_ready`.
  - When `out_ready` is seen, go → IDLE.
  - `in_ready`=0 in WAIT and RESP.
- **Size decode**
  - Loads: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; 111 is illegal.
  - Stores: 000 sb, 001 sh, 010 sw, 011 sd; 1xx is illegal.
- **Alignment**
  - Let o = `addr[2:0]` and size = 2^`funct3[1:0]` bytes.
  - An access is misaligned when `o % size != 0`, so no access ever crosses an 8-byte boundary.
- **Store lanes**
  - `mem_wdata = wdata << 8*o`.
  - `mem_mask = ((1<<size)-1) << o`, truncated to 8 bits.
- **Load extract**
  - `d = mem_rdata >> 8*o`, then keep the low 8·size bits.
  - Sign-extend when `funct3[2]`=0, otherwise zero-extend.
- **Idle outputs**
  - `mem_*` addresses, data and mask are driven from the latched request and are don't-care outside WAIT.
  - `mem_ren` and `mem_wen` are decoded from state and are 0 outside WAIT.

## Timing
- **Reset:** state=IDLE; `in_ready`=1; `out_valid`, `out_err`, `mem_ren`, `mem_wen`=0; `out_rdata`=0; `out_rd`=0.
- **Valid request:** accepted at edge 0, WAIT for cycles 1..`MEM_LAT`, `out_valid` from cycle `MEM_LAT`+1.
- **Error request:** `out_valid` at cycle 1.
- **Throughput:** best case one request per `MEM_LAT`+2 cycles. `in_ready` does not re-rise in the same cycle as the output handshake.
- **Reset mid-operation:** asserting `rst_n` low returns to IDLE immediately, and `mem_wen`/`mem_ren` drop asynchronously.
  - A store interrupted before its counter==0 cycle never writes.
  - A pending response is discarded.
- **Input stability:** `in_*` need only be valid in the accepting cycle.

## Structure
- **Package `npc_lsu_pkg`:**
  - state enum `lsu_state_t`;
  - funct3 constants (`F3_LB`…`F3_LWU`, `F3_SB`…`F3_SD`);
  - function `lsu_size_bytes(funct3)`.
- **Sub-module `lsu_align`:** purely combinational.
  - Inputs: funct3, offset, store data, `mem_rdata`.
  - Outputs: `mem_wdata`, `mem_mask`, extended load data, misaligned/illegal flags.
- **FSM and counter** stay in `lsu_ctrl`.

## Test plan
- sd, addr 0x80000010, data 0x1122334455667788, `MEM_LAT`=1 → one `mem_wen` pulse at cycle 1, waddr 0x80000010, mask 0xFF; `out_valid` at cycle 2, `out_err`=0.
- sb, addr 0x80000013, data 0xAB → waddr 0x80000010, mask 0x08, `mem_wdata[31:24]`=0xAB.
- lb then lbu, addr 0x80000013, `mem_rdata`=0x0000000080000000 → `out_rdata` 0xFFFFFFFFFFFFFF80 for lb, then 0x0000000000000080 for lbu; `out_rd` echoes the tag.
- lw, addr 0x80000006 → no `mem_ren`/`mem_wen`; `out_valid` at cycle 1 with `out_err`=1 and `out_rdata`=0. Same outcome for load funct3=111.
- ld with `out_ready` held low for 3 cycles → `out_valid`, `out_rdata` and `out_rd` stay stable and `in_ready` stays 0; IDLE on the cycle after `out_ready` rises.
- `MEM_LAT`=4, sd accepted, `rst_n` pulsed low during the 2nd WAIT cycle → `mem_wen` is never asserted; outputs return to reset values; the next request completes normally.
